// File: rtl/strand_complement_arbiter_if.sv
// Requester-side and result-side handshake bundle for the shared complement engine.
interface strand_complement_arbiter_if #(
  parameter int unsigned R = 4,
  parameter int unsigned N = 4
);
  localparam int unsigned WW  = 2 * N;
  localparam int unsigned IDW = (R > 1) ? $clog2(R) : 1;

  logic [R-1:0]    req_valid;
  logic [R-1:0]    req_last;
  logic [R*WW-1:0] req_word;
  logic [R-1:0]    req_rev;
  logic [R-1:0]    req_ready;
  logic            out_valid;
  logic            out_ready;
  logic [WW-1:0]   out_word;
  logic [IDW-1:0]  out_id;
  logic            out_last;

  modport slave (
    input  req_valid, req_last, req_word, req_rev, out_ready,
    output req_ready, out_valid, out_word, out_id, out_last
  );

  modport master (
    output req_valid, req_last, req_word, req_rev, out_ready,
    input  req_ready, out_valid, out_word, out_id, out_last
  );
endinterface

// File: rtl/strand_complement_arbiter.sv
// Round-robin burst arbiter feeding one registered DNA digit (reverse-)complement stage.
module strand_complement_arbiter #(
  parameter int unsigned R  = 4,
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  strand_complement_arbiter_if.slave  bus,
  output logic                        busy,
  output logic [CW-1:0]               word_cnt
);
  localparam int unsigned WW  = 2 * N;
  localparam int unsigned IDW = (R > 1) ? $clog2(R) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SERVE = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic           rev_q, rev_d;
  logic           out_valid_q, out_valid_d;
  logic [WW-1:0]  out_word_q, out_word_d;
  logic [IDW-1:0] out_id_q, out_id_d;
  logic           out_last_q, out_last_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;

  logic           hit_c;
  logic [IDW-1:0] pick_c;
  int unsigned    idx_c;
  logic [WW-1:0]  word_c;
  logic           valid_c;
  logic           last_c;
  logic [WW-1:0]  cplx_c;
  logic [R-1:0]   ready_c;
  logic           accept_c;

  // First requesting index at or after rr_ptr, wrapping modulo R
  always_comb begin
    hit_c  = 1'b0;
    pick_c = '0;
    idx_c  = 0;
    for (int unsigned i = 0; i < R; i++) begin
      idx_c = (32'(rr_ptr_q) + i) % R;
      if (!hit_c && bus.req_valid[IDW'(idx_c)]) begin
        hit_c  = 1'b1;
        pick_c = IDW'(idx_c);
      end
    end
  end

  // Granted lane select
  always_comb begin
    word_c  = '0;
    valid_c = 1'b0;
    last_c  = 1'b0;
    for (int unsigned i = 0; i < R; i++) begin
      if (grant_q == IDW'(i)) begin
        word_c  = bus.req_word[i*WW +: WW];
        valid_c = bus.req_valid[i];
        last_c  = bus.req_last[i];
      end
    end
  end

  // Per-digit complement flips bit0; rev_q mirrors the digit order
  always_comb begin
    cplx_c = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cplx_c[2*k +: 2] = (rev_q ? word_c[2*(N-1-k) +: 2] : word_c[2*k +: 2]) ^ 2'b01;
    end
  end

  always_comb begin
    ready_c = '0;
    if (rst && (state_q == S_SERVE)) begin
      ready_c[grant_q] = !out_valid_q || bus.out_ready;
    end
    accept_c = (state_q == S_SERVE) && valid_c && ready_c[grant_q];
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    rev_d       = rev_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_id_d    = out_id_q;
    out_last_d  = out_last_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (hit_c) begin
          grant_d = pick_c;
          rev_d   = bus.req_rev[pick_c];
          state_d = S_SERVE;
        end
      end
      S_SERVE: begin
        if (accept_c && last_c) begin
          state_d  = S_IDLE;
          rr_ptr_d = IDW'((32'(grant_q) + 1) % R);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new accept reloads the register even while the old word drains
    if (accept_c) begin
      out_valid_d = 1'b1;
      out_word_d  = cplx_c;
      out_id_d    = grant_q;
      out_last_d  = last_c;
      cnt_d       = cnt_q + CW'(1);
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    busy_d = (state_d == S_SERVE) || out_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      rev_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_id_q    <= '0;
      out_last_q  <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      rev_q       <= rev_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_id_q    <= out_id_d;
      out_last_q  <= out_last_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_word  = out_word_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_last  = out_last_q;
  assign busy          = busy_q;
  assign word_cnt      = cnt_q;

endmodule

// File: tb/tb_strand_complement_arbiter.sv
// Randomized bench for strand_complement_arbiter against a transaction-level reference model.
module tb_strand_complement_arbiter;
  localparam int unsigned R    = 4;
  localparam int unsigned N    = 4;
  localparam int unsigned CW   = 4;
  localparam int unsigned WW   = 2 * N;
  localparam int unsigned MAXB = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          busy;
  logic [CW-1:0] word_cnt;

  strand_complement_arbiter_if #(.R(R), .N(N)) bus ();

  strand_complement_arbiter #(.R(R), .N(N), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Burst sources
  int unsigned   src_len [R];
  int unsigned   src_pos [R];
  logic [WW-1:0] src_word [R][MAXB];
  bit            src_rev [R];
  int unsigned   gap_pct = 0;
  int unsigned   ordy_pct = 100;
  int            ordy_force = 1;
  bit            rand_load = 1'b0;

  // Reference model: one arbitration slot, one-entry output holding register
  bit            m_serve;
  int            m_grant;
  int            m_ptr;
  bit            m_rev;
  bit            m_ov;
  logic [WW-1:0] m_word;
  int            m_id;
  bit            m_last;
  int unsigned   m_cnt;
  int unsigned   acc_total = 0;
  int unsigned   drained = 0;
  int            grant_log[$];

  function automatic void load_burst(input int i, input int unsigned len, input bit rev);
    src_len[i] = len;
    src_pos[i] = 0;
    src_rev[i] = rev;
    for (int k = 0; k < int'(MAXB); k++) src_word[i][k] = WW'($urandom);
  endfunction

  function automatic void clear_sources();
    for (int i = 0; i < int'(R); i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end
  endfunction

  function automatic void model_reset();
    m_serve = 1'b0; m_grant = 0; m_ptr = 0; m_rev = 1'b0;
    m_ov = 1'b0; m_word = '0; m_id = 0; m_last = 1'b0; m_cnt = 0;
  endfunction

  function automatic logic [WW-1:0] ref_f(input logic [WW-1:0] w, input bit rev);
    logic [WW-1:0] r;
    int src;
    int d;
    r = '0;
    for (int k = 0; k < int'(N); k++) begin
      src = rev ? (int'(N) - 1 - k) : k;
      d   = int'((w >> (2 * src)) & 3);
      r   = r | (WW'(d ^ 1) << (2 * k));
    end
    return r;
  endfunction

  function automatic bit all_done();
    for (int i = 0; i < int'(R); i++) if (src_pos[i] < src_len[i]) return 1'b0;
    return !m_serve && !m_ov;
  endfunction

  // One clock: drive at posedge+1, check at negedge, advance model at posedge
  task automatic cycle();
    logic [R-1:0]    v, l, rv, erdy;
    logic [R*WW-1:0] wd;
    logic            ordy;
    bit              acc, was_serve;
    int              g;
    v = '0; l = '0; rv = '0; wd = '0; erdy = '0;
    for (int i = 0; i < int'(R); i++) begin
      if (rand_load && src_pos[i] >= src_len[i] && $urandom_range(99) < 15)
        load_burst(i, $urandom_range(1, 6), 1'($urandom_range(1)));
      wd[i*WW +: WW] = WW'($urandom);
      l[i]  = 1'($urandom_range(1));
      rv[i] = 1'($urandom_range(1));
      if (src_pos[i] < src_len[i] && $urandom_range(99) >= gap_pct) begin
        v[i]           = 1'b1;
        wd[i*WW +: WW] = src_word[i][src_pos[i]];
        l[i]           = (src_pos[i] == src_len[i] - 1);
        if (src_pos[i] == 0) rv[i] = src_rev[i];
      end
    end
    ordy = (ordy_force >= 0) ? 1'(ordy_force) : ($urandom_range(99) < ordy_pct);
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_word  = wd;
    bus.req_rev   = rv;
    bus.out_ready = ordy;

    @(negedge clk);
    if (rst && m_serve) erdy[m_grant] = !m_ov || ordy;
    check_val("req_ready", bus.req_ready, erdy);
    check_val("out_valid", bus.out_valid, m_ov);
    check_val("out_word", bus.out_word, m_word);
    check_val("out_id", bus.out_id, m_id);
    check_val("out_last", bus.out_last, m_last);
    check_val("busy", busy, m_serve || m_ov);
    check_val("word_cnt", word_cnt, m_cnt);

    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      was_serve = m_serve;
      acc = m_serve && v[m_grant] && erdy[m_grant];
      if (m_ov && ordy) drained++;
      if (acc) begin
        m_ov   = 1'b1;
        m_word = ref_f(wd[m_grant*WW +: WW], m_rev);
        m_id   = m_grant;
        m_last = l[m_grant];
        m_cnt  = (m_cnt + 1) % (1 << CW);
        acc_total++;
        src_pos[m_grant]++;
        if (l[m_grant]) begin
          m_serve = 1'b0;
          m_ptr   = (m_grant + 1) % int'(R);
        end
      end else if (m_ov && ordy) begin
        m_ov = 1'b0;
      end
      if (!was_serve && v != '0) begin
        g = m_ptr;
        while (!v[g]) g = (g + 1) % int'(R);
        m_serve = 1'b1;
        m_grant = g;
        m_rev   = rv[g];
        grant_log.push_back(g);
      end
    end
    #1;
  endtask

  task automatic run_until_done(input int budget);
    int n;
    n = 0;
    while (!all_done() && n < budget) begin
      cycle();
      n++;
    end
    check_val("drain_timeout", all_done(), 1);
  endtask

  task automatic reset_cycle();
    clear_sources();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
  endtask

  initial begin
    int unsigned start, n, d0;
    logic [WW-1:0] held;
    rst = 1'b0;
    bus.req_valid = '0; bus.req_last = '0; bus.req_word = '0; bus.req_rev = '0;
    bus.out_ready = 1'b0;
    clear_sources();
    model_reset();
    @(posedge clk);
    #1;
    cycle();
    cycle();
    rst = 1'b1;

    // Single-word complement
    load_burst(0, 1, 1'b0);
    src_word[0][0] = 8'h1B;
    run_until_done(50);
    check_val("single_word", bus.out_word, 8'h4E);
    check_val("single_id", bus.out_id, 0);
    check_val("single_last", bus.out_last, 1);
    check_val("single_cnt", word_cnt, 1);

    // Reverse-complement, then plain on the same requester
    load_burst(2, 1, 1'b1);
    src_word[2][0] = 8'h1B;
    run_until_done(50);
    check_val("revcomp_word", bus.out_word, 8'hB1);
    check_val("revcomp_id", bus.out_id, 2);
    load_burst(2, 1, 1'b0);
    src_word[2][0] = 8'h00;
    run_until_done(50);
    check_val("comp_zero_word", bus.out_word, 8'h55);

    // Round-robin across simultaneous 2-word bursts
    reset_cycle();
    grant_log.delete();
    for (int i = 0; i < int'(R); i++) load_burst(i, 2, 1'($urandom_range(1)));
    run_until_done(100);
    load_burst(0, 2, 1'b0);
    run_until_done(50);
    check_val("rr_count", grant_log.size(), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      check_val($sformatf("rr_order%0d", i), grant_log[i], i % int'(R));

    // Backpressure holds the output and blocks the requester
    load_burst(1, 3, 1'b0);
    start = acc_total;
    n = 0;
    while (acc_total == start && n < 20) begin cycle(); n++; end
    check_val("bp_first_acc", acc_total - start, 1);
    ordy_force = 0;
    held = bus.out_word;
    d0 = drained;
    repeat (5) begin
      cycle();
      check_val("bp_hold", bus.out_word, held);
      check_val("bp_ready1", bus.req_ready[1], 0);
    end
    ordy_force = 1;
    run_until_done(50);
    check_val("bp_words", acc_total - start, 3);
    check_val("bp_drained", drained - d0, 3);

    // Mid-burst reset
    load_burst(3, 4, 1'b0);
    start = acc_total;
    n = 0;
    while (acc_total - start < 2 && n < 30) begin cycle(); n++; end
    check_val("mr_two_acc", acc_total - start, 2);
    reset_cycle();
    check_val("mr_out_valid", bus.out_valid, 0);
    check_val("mr_word_cnt", word_cnt, 0);
    check_val("mr_busy", busy, 0);
    grant_log.delete();
    load_burst(3, 1, 1'b0);
    load_burst(0, 1, 1'b0);
    run_until_done(50);
    check_val("mr_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

    // Counter wrap
    reset_cycle();
    load_burst(0, 17, 1'b1);
    run_until_done(100);
    check_val("cnt_wrap", word_cnt, 1);

    // Randomized traffic with gaps and random backpressure
    rand_load = 1'b1;
    gap_pct = 25;
    ordy_force = -1;
    ordy_pct = 70;
    repeat (2000) cycle();
    rand_load = 1'b0;
    run_until_done(1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
